hasti_debug_master: RTL
=======================

HASTI_DEBUG_MASTER -- requirements
Module: hasti_debug_master

Interface
REQ-001 SHALL have parameter AUTO_INC, default 1: when 1, the address register advances by 4 after every completed READ or WRITE.
REQ-002 SHALL have parameter HPROT_VAL, default 4'b0011: the constant value driven on hprot.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port io_req_ready, output, 1 bit: command accepted when high with io_req_valid.
REQ-006 SHALL have port io_req_valid, input, 1 bit: command present.
REQ-007 SHALL have port io_req_bits_cmd, input, 2 bits: 0=ADDR, 1=WRITE, 2=READ, 3=STATUS.
REQ-008 SHALL have port io_req_bits_data, input, 32 bits: command operand.
REQ-009 SHALL have port io_resp_ready, input, 1 bit: response consumed when high with io_resp_valid.
REQ-010 SHALL have port io_resp_valid, output, 1 bit: response present.
REQ-011 SHALL have port io_resp_bits_ack, output, 1 bit: 1=success, 0=bus error.
REQ-012 SHALL have port io_resp_bits_data, output, 32 bits: response payload.
REQ-013 SHALL have AHB-lite master ports: haddr out 32; hwrite out 1; hsize out 3; hburst out 3; hprot out 4; htrans out 2; hmastlock out 1; hwdata out 32; hrdata in 32; hready in 1; hresp in 1.

Function
REQ-014 SHALL implement the FSM IDLE -> ADDR_PH -> DATA_PH -> RESP -> IDLE for READ/WRITE, and IDLE -> RESP -> IDLE for ADDR/STATUS.
REQ-015 SHALL drive io_req_ready=1 only in IDLE; accepting a command SHALL take exactly one cycle.
REQ-016 ADDR SHALL load addr_reg with {data[31:2],2'b00}; response: ack=1, data=new addr_reg.
REQ-017 STATUS SHALL leave state unchanged; response: ack=1, data=addr_reg.
REQ-018 WRITE SHALL latch data into wdata_reg on acceptance; READ SHALL ignore io_req_bits_data.
REQ-019 ADDR_PH: htrans=2'b10 (NONSEQ), haddr=addr_reg, hwrite=1 for WRITE and 0 for READ; the FSM SHALL advance to DATA_PH on the first edge with hready=1, and SHALL hold otherwise.
REQ-020 DATA_PH: htrans=2'b00, hwdata=wdata_reg; the FSM SHALL wait for hready=1, then capture ack=!hresp and data=hrdata (READ) or wdata_reg (WRITE), and enter RESP.
REQ-021 A two-cycle ERROR response (hresp=1 with hready=0, then hresp=1 with hready=1) SHALL yield ack=0; hresp sampled with hready=0 SHALL be ignored.
REQ-022 On completion of the DATA_PH, if AUTO_INC=1, addr_reg SHALL advance by 4 modulo 2^32 (0xFFFFFFFC -> 0x00000000), including on error.
REQ-023 RESP: io_resp_valid=1 with registered, stable payload until io_resp_ready=1; the FSM SHALL then return to IDLE.
REQ-024 Minimum latency: READ/WRITE with hready held high SHALL assert io_resp_valid 3 cycles after the accept edge; ADDR/STATUS SHALL assert it 1 cycle after.
REQ-025 hsize SHALL be constant 3'b010, hburst 3'b000, hmastlock 0, and hprot HPROT_VAL.
REQ-026 Only one command SHALL be outstanding; io_req_ready SHALL stay 0 from acceptance until the response handshake completes.
REQ-027 haddr and hwrite SHALL hold their values outside ADDR_PH; htrans SHALL be 2'b00 in every state except ADDR_PH.

Reset
REQ-028 reset=0 SHALL immediately force: FSM=IDLE, addr_reg=0, wdata_reg=0, io_req_ready=1 (after reset released), io_resp_valid=0, resp ack/data=0, htrans=2'b00, haddr=0, hwrite=0, hwdata=0.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer and discard any pending response; no response SHALL be emitted after deassertion.

Verification
REQ-030 ADDR 0x00001003 -> resp ack=1, data=0x00001000; then STATUS -> ack=1, data=0x00001000.
REQ-031 ADDR 0x100, WRITE 0xDEADBEEF, hready=1 -> one NONSEQ write at haddr=0x100, hwdata=0xDEADBEEF in the next cycle, ack=1, data=0xDEADBEEF; STATUS -> 0x104.
REQ-032 READ at 0x104 with slave inserting 3 wait states, hrdata=0x12345678 -> io_resp_valid exactly 3 cycles later than zero-wait, ack=1, data=0x12345678.
REQ-033 READ with two-cycle ERROR response -> ack=0, addr_reg still incremented by 4.
REQ-034 ADDR 0xFFFFFFFC, READ -> STATUS returns 0x00000000; io_resp_ready held low 5 cycles -> payload stable and io_req_ready=0 throughout.
REQ-035 reset asserted during DATA_PH -> htrans=0 and io_resp_valid=0 immediately; after release, IDLE with io_req_ready=1 and no stray response.

Source files
------------

// File: rtl/hasti_debug_master.sv
`default_nettype none
// ============================================================================
// Module   : hasti_debug_master
// Purpose  : Debug command port (ADDR / WRITE / READ / STATUS) bridged onto a
//            single-transfer AHB-lite master, one command outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module hasti_debug_master #(
    parameter bit         AUTO_INC  = 1'b1,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,
    output logic        io_req_ready,
    input  logic        io_req_valid,
    input  logic [1:0]  io_req_bits_cmd,
    input  logic [31:0] io_req_bits_data,
    input  logic        io_resp_ready,
    output logic        io_resp_valid,
    output logic        io_resp_bits_ack,
    output logic [31:0] io_resp_bits_data,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [1:0]  htrans,
    output logic        hmastlock,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam logic [1:0] CMD_ADDR      = 2'd0;
    localparam logic [1:0] CMD_WRITE     = 2'd1;
    localparam logic [1:0] CMD_READ      = 2'd2;
    localparam logic [1:0] CMD_STATUS    = 2'd3;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR_PH = 2'd1,
        ST_DATA_PH = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    // Fixed single-word, non-burst, unlocked transfer attributes
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hmastlock = 1'b0;
    assign hprot     = HPROT_VAL;
    // Write data only changes on acceptance of a WRITE, so it is stable
    // throughout the data phase without a separate register
    assign hwdata    = wdata_reg;

    // Command sequencer: accept, run the AHB address/data phases, hold response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ST_IDLE;
            addr_reg          <= 32'd0;
            wdata_reg         <= 32'd0;
            io_req_ready      <= 1'b1;
            io_resp_valid     <= 1'b0;
            io_resp_bits_ack  <= 1'b0;
            io_resp_bits_data <= 32'd0;
            htrans            <= HTRANS_IDLE;
            haddr             <= 32'd0;
            hwrite            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io_req_valid && io_req_ready) begin
                        io_req_ready <= 1'b0;
                        case (io_req_bits_cmd)
                            CMD_ADDR: begin
                                addr_reg          <= {io_req_bits_data[31:2], 2'b00};
                                io_resp_bits_ack  <= 1'b1;
                                io_resp_bits_data <= {io_req_bits_data[31:2], 2'b00};
                                io_resp_valid     <= 1'b1;
                                state             <= ST_RESP;
                            end
                            CMD_STATUS: begin
                                io_resp_bits_ack  <= 1'b1;
                                io_resp_bits_data <= addr_reg;
                                io_resp_valid     <= 1'b1;
                                state             <= ST_RESP;
                            end
                            CMD_WRITE: begin
                                wdata_reg <= io_req_bits_data;
                                haddr     <= addr_reg;
                                hwrite    <= 1'b1;
                                htrans    <= HTRANS_NONSEQ;
                                state     <= ST_ADDR_PH;
                            end
                            default: begin
                                haddr  <= addr_reg;
                                hwrite <= 1'b0;
                                htrans <= HTRANS_NONSEQ;
                                state  <= ST_ADDR_PH;
                            end
                        endcase
                    end
                end
                ST_ADDR_PH: begin
                    // Address is taken by the slave on the first ready edge
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        state  <= ST_DATA_PH;
                    end
                end
                ST_DATA_PH: begin
                    // hresp only counts on the closing (ready) cycle of an error
                    if (hready) begin
                        io_resp_bits_ack  <= ~hresp;
                        io_resp_bits_data <= hwrite ? wdata_reg : hrdata;
                        io_resp_valid     <= 1'b1;
                        if (AUTO_INC) begin
                            addr_reg <= addr_reg + 32'd4;
                        end
                        state <= ST_RESP;
                    end
                end
                default: begin
                    if (io_resp_ready) begin
                        io_resp_valid <= 1'b0;
                        io_req_ready  <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
